// File: rtl/ps2_host_rx.sv
// Host-side PS/2 receiver: sync + glitch filter, frame/parity checks, FWFT byte FIFO.
// Define PS2_RX_KEYDECODE_EN to build the scancode decoder that drives key_code.
module ps2_host_rx #(
    parameter int FILTER    = 8,
    parameter int TIMEOUT   = 20000,
    parameter int FIFO_BITS = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_rd,
    input  logic        err_clr,
    output logic        rx_overflow,
    output logic        rx_parity_err,
    output logic        rx_frame_err,
    output logic [10:0] key_code
);
    localparam int DEPTH  = 1 << FIFO_BITS;
    localparam int FILT_W = $clog2(FILTER + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t              state_q, state_d;
    logic [1:0]          clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic                filt_q, filt_d, filt_dly_q, filt_dly_d, fall_q, fall_d;
    logic [FILT_W-1:0]   filt_cnt_q, filt_cnt_d;
    logic [TO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic                par_q, par_d;
    logic [FIFO_BITS:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;
    logic [7:0]          mem_q [DEPTH];

    logic clk_s, dat_s, tmo;
    logic push, frame_set, par_set;
    logic empty, full, pop, wr_en, ovf_set;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    // Filtered clock only moves after FILTER consecutive disagreeing samples.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FILT_W'(FILTER - 1)) filt_d = clk_s;
            else filt_cnt_d = filt_cnt_q + 1'b1;
        end
        filt_dly_d = filt_q;
        fall_d     = filt_dly_q & ~filt_q;
    end

    always_comb begin
        tmo       = (state_q != S_IDLE) && !fall_q && (tmo_cnt_q == TO_W'(TIMEOUT - 1));
        tmo_cnt_d = (state_q == S_IDLE || fall_q || tmo) ? '0 : tmo_cnt_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        if (tmo) begin
            state_d = S_IDLE;
        end else if (fall_q) begin
            case (state_q)
                S_IDLE:   if (!dat_s) state_d = S_DATA;
                S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        push      = 1'b0;
        frame_set = 1'b0;
        par_set   = 1'b0;
        if (tmo) begin
            frame_set = 1'b1;
        end else if (fall_q) begin
            case (state_q)
                S_IDLE: frame_set = dat_s;
                S_STOP: begin
                    if (!dat_s) frame_set = 1'b1;
                    else if (^{shift_q, par_q}) push = 1'b1;
                    else par_set = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        if (fall_q && !tmo) begin
            case (state_q)
                S_IDLE: bit_cnt_d = '0;
                S_DATA: begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                S_PARITY: par_d = dat_s;
                default: ;
            endcase
        end
    end

    // Extra pointer bit separates full from empty; a same-cycle pop makes room for a push.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[FIFO_BITS] != rd_ptr_q[FIFO_BITS]) &&
                   (wr_ptr_q[FIFO_BITS-1:0] == rd_ptr_q[FIFO_BITS-1:0]);
        pop      = rx_rd && !empty;
        wr_en    = push && (!full || pop);
        ovf_set  = push && full && !pop;
        wr_ptr_d = wr_ptr_q + (FIFO_BITS+1)'(wr_en);
        rd_ptr_d = rd_ptr_q + (FIFO_BITS+1)'(pop);
        ovf_d    = !err_clr && (ovf_q || ovf_set);
        perr_d   = !err_clr && (perr_q || par_set);
        ferr_d   = !err_clr && (ferr_q || frame_set);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            filt_dly_q <= 1'b1;
            fall_q     <= 1'b0;
            filt_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_dly_d;
            fall_q     <= fall_d;
            filt_cnt_q <= filt_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_q      <= par_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_en) mem_q[wr_ptr_q[FIFO_BITS-1:0]] <= shift_q;
    end

    assign rx_valid      = !empty;
    assign rx_data       = empty ? 8'h00 : mem_q[rd_ptr_q[FIFO_BITS-1:0]];
    assign rx_overflow   = ovf_q;
    assign rx_parity_err = perr_q;
    assign rx_frame_err  = ferr_q;

`ifdef PS2_RX_KEYDECODE_EN
    logic        ext_q, ext_d, rel_q, rel_d;
    logic [10:0] key_q, key_d;

    // Prefix bytes only arm flags; the following code byte emits the event.
    always_comb begin
        ext_d = ext_q;
        rel_d = rel_q;
        key_d = key_q;
        if (push) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                rel_d = 1'b1;
            end else if (shift_q == 8'hE1) begin
                ext_d = 1'b0;
                rel_d = 1'b0;
            end else begin
                key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
            key_q <= '0;
        end else begin
            ext_q <= ext_d;
            rel_q <= rel_d;
            key_q <= key_d;
        end
    end

    assign key_code = key_q;
`else
    assign key_code = '0;
`endif

endmodule

// File: tb/tb_ps2_host_rx.sv
// Directed/random bench for ps2_host_rx against a queue-based model of received bytes and flags.
module tb_ps2_host_rx;
    localparam int FILTER    = 4;
    localparam int TIMEOUT   = 300;
    localparam int FIFO_BITS = 4;
    localparam int DEPTH     = 16;
    localparam int HALF      = 10;
`ifdef PS2_RX_KEYDECODE_EN
    localparam bit DEC_ON = 1'b1;
`else
    localparam bit DEC_ON = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, rx_rd = 1'b0, err_clr = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_overflow, rx_parity_err, rx_frame_err;
    logic [10:0] key_code;

    int checks = 0, failures = 0;
    logic [7:0]  exp_q[$];
    bit          m_ovf, m_par, m_frm, m_ext, m_rel;
    logic [10:0] m_key;

    always #5 clk_sys = ~clk_sys;

    ps2_host_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .FIFO_BITS(FIFO_BITS)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_rd(rx_rd), .err_clr(err_clr),
        .rx_overflow(rx_overflow), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .key_code(key_code)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf = 0; m_par = 0; m_frm = 0; m_ext = 0; m_rel = 0; m_key = '0;
    endtask

    task automatic model_rx(input logic [7:0] b, input bit bad_par, input bit stop);
        if (!stop) m_frm = 1;
        else if (bad_par) m_par = 1;
        else begin
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_rel = 1;
            else if (b == 8'hE1) begin m_ext = 0; m_rel = 0; end
            else begin
                m_key = {~m_key[10], ~m_rel, m_ext, b};
                m_ext = 0; m_rel = 0;
            end
            if (exp_q.size() == DEPTH) m_ovf = 1;
            else exp_q.push_back(b);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk($sformatf("%s overflow", tag), 32'(rx_overflow), 32'(m_ovf));
        chk($sformatf("%s parity_err", tag), 32'(rx_parity_err), 32'(m_par));
        chk($sformatf("%s frame_err", tag), 32'(rx_frame_err), 32'(m_frm));
        chk($sformatf("%s key_code", tag), 32'(key_code), DEC_ON ? 32'(m_key) : 32'd0);
    endtask

    task automatic clear_errs();
        err_clr = 1; tick(); err_clr = 0;
        m_ovf = 0; m_par = 0; m_frm = 0;
    endtask

    // Emits the first nbits bits of a frame; lat = cycles from first low sample of stop to rx_valid.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop,
                              input int nbits, input bit rd_on_push, output int lat);
        logic [10:0] bits;
        bits = {stop, ~(^b) ^ bad_par, b, 1'b0};
        lat = -1;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) tick();
            ps2_clk = 0;
            for (int c = 0; c < HALF; c++) begin
                tick();
                if (i == 10 && lat < 0 && rx_valid) lat = c;
                if (i == 10 && rd_on_push && c == FILTER + 2) rx_rd = 1;
                if (i == 10 && rd_on_push && c == FILTER + 3) rx_rd = 0;
            end
            ps2_clk = 1;
        end
        ps2_data = 1;
        repeat (HALF) tick();
    endtask

    task automatic send_good(input logic [7:0] b);
        int lat;
        send_frame(b, 1'b0, 1'b1, 11, 1'b0, lat);
        model_rx(b, 1'b0, 1'b1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() > 0) begin
            chk($sformatf("%s valid[%0d]", tag, n), 32'(rx_valid), 32'd1);
            chk($sformatf("%s data[%0d]", tag, n), 32'(rx_data), 32'(exp_q[0]));
            rx_rd = 1; tick(); rx_rd = 0;
            void'(exp_q.pop_front());
            n++;
        end
        chk($sformatf("%s empty valid", tag), 32'(rx_valid), 32'd0);
        chk($sformatf("%s empty data", tag), 32'(rx_data), 32'd0);
    endtask

    initial begin
        int lat;
        logic [7:0] b;
        model_reset();
        repeat (3) tick();
        chk("reset valid", 32'(rx_valid), 32'd0);
        chk("reset data", 32'(rx_data), 32'd0);
        chk_flags("reset");
        reset = 0;
        repeat (5) tick();

        // First byte: latency from stop-bit low sample to rx_valid
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, lat);
        model_rx(8'h1C, 1'b0, 1'b1);
        chk("latency", 32'(lat), 32'(FILTER + 3));
        chk_flags("1C");
        rx_rd = 1; tick(); rx_rd = 0;
        chk("pop valid", 32'(rx_valid), 32'd0);
        void'(exp_q.pop_front());
        rx_rd = 1; tick(); rx_rd = 0;
        chk("pop empty ignored", 32'(rx_valid), 32'd0);

        // Parity error, then clear
        send_frame(8'h55, 1'b1, 1'b1, 11, 1'b0, lat);
        model_rx(8'h55, 1'b1, 1'b1);
        chk("parity no push", 32'(rx_valid), 32'd0);
        chk_flags("parity");
        clear_errs();
        chk_flags("parity clr");

        // err_clr held across an error wins
        err_clr = 1;
        send_frame(8'h55, 1'b1, 1'b1, 11, 1'b0, lat);
        tick(); err_clr = 0; tick();
        chk("clr priority", 32'(rx_parity_err), 32'd0);

        // Bad stop bit
        send_frame(8'hA3, 1'b0, 1'b0, 11, 1'b0, lat);
        model_rx(8'hA3, 1'b0, 1'b0);
        chk("stop0 no push", 32'(rx_valid), 32'd0);
        chk_flags("stop0");
        clear_errs();

        // Timeout after start + 5 data bits
        send_frame(8'h3C, 1'b0, 1'b1, 6, 1'b0, lat);
        repeat (TIMEOUT / 2) tick();
        chk("pre-timeout frame_err", 32'(rx_frame_err), 32'd0);
        repeat (TIMEOUT) tick();
        m_frm = 1;
        chk("timeout no push", 32'(rx_valid), 32'd0);
        chk_flags("timeout");
        clear_errs();
        send_good(8'h29);
        chk_flags("29");
        drain("29");

        // Random good bytes
        for (int i = 0; i < 5; i++) send_good(8'($urandom));
        chk_flags("random");
        drain("random");

        // Overflow: DEPTH+1 bytes with no reads
        for (int i = 0; i <= DEPTH; i++) send_good(8'($urandom));
        chk_flags("overflow");
        drain("overflow");
        clear_errs();
        chk_flags("overflow clr");

        // Full FIFO with pop on the push edge: no overflow
        for (int i = 0; i < DEPTH; i++) send_good(8'($urandom));
        chk("full valid", 32'(rx_valid), 32'd1);
        b = 8'($urandom);
        send_frame(b, 1'b0, 1'b1, 11, 1'b1, lat);
        void'(exp_q.pop_front());
        model_rx(b, 1'b0, 1'b1);
        chk_flags("push+pop full");
        drain("push+pop full");

        // Scancode sequences from a fresh reset
        reset = 1; tick(); reset = 0; model_reset(); tick();
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        chk_flags("E0 F0 75");
        send_good(8'h1C);
        chk_flags("1C key");
        send_good(8'hE1);
        send_good(8'h14);
        chk_flags("E1 14");
        drain("keys");

        // Short glitch on ps2_clk while idle
        ps2_clk = 0; tick(); tick(); ps2_clk = 1;
        repeat (20) tick();
        chk("glitch frame_err", 32'(rx_frame_err), 32'd0);
        chk("glitch valid", 32'(rx_valid), 32'd0);
        send_good(8'h5A);
        chk_flags("after glitch");
        drain("after glitch");

        // Reset mid-frame, then a full frame
        send_good(8'h12);
        send_frame(8'h47, 1'b0, 1'b1, 5, 1'b0, lat);
        reset = 1; tick(); tick();
        model_reset();
        chk("midreset valid", 32'(rx_valid), 32'd0);
        chk("midreset data", 32'(rx_data), 32'd0);
        chk_flags("midreset");
        reset = 0;
        repeat (5) tick();
        send_good(8'h6B);
        chk_flags("post reset");
        drain("post reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
